axis_row_padder: RTL and testbench

- Upstream framing stage in front of the AXI-Stream-to-BRAM adapter's slave stream port.
- Accepts an arbitrary-length 32-bit AXI-Stream packet and emits it as whole BRAM rows of ROW_WORDS words. The last row is zero-padded, and TLAST is asserted only on the final word of the final row.
- Enforces a per-packet row limit so the adapter never writes past its bound address. Excess input is discarded, and a sticky error is raised.

---
 rtl/axis_row_padder.sv | 179 +++++++++++++++++
 tb/tb_axis_row_padder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_row_padder.sv
// Frames an arbitrary-length AXI-Stream packet into whole rows of ROW_WORDS words,
// zero-padding the final row and truncating packets that exceed a per-packet row limit.
module axis_row_padder #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned ROW_WORDS          = 36,
    parameter int unsigned ROW_CNT_WIDTH      = 12,
    parameter logic [C_AXIS_TDATA_WIDTH-1:0] PAD_WORD = '0
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                              s00_axis_tvalid,
    input  logic                              s00_axis_tlast,
    output logic                              s00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                              m00_axis_tvalid,
    output logic                              m00_axis_tlast,
    input  logic                              m00_axis_tready,
    input  logic [ROW_CNT_WIDTH-1:0]          max_rows,
    output logic [ROW_CNT_WIDTH-1:0]          rows_emitted,
    output logic                              overflow_err,
    input  logic                              err_clr
);

    localparam int unsigned STRB_W = C_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned WC_W   = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(ROW_WORDS - 1);

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_PAD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [WC_W-1:0]                 word_cnt_q, word_cnt_d;
    logic [ROW_CNT_WIDTH-1:0]        row_cnt_q, row_cnt_d;
    logic                            pkt_q, pkt_d;
    logic [ROW_CNT_WIDTH-1:0]        rows_q, rows_d;
    logic                            err_q, err_d;
    logic                            tvalid_q, tvalid_d;
    logic [C_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [STRB_W-1:0]               tstrb_q, tstrb_d;
    logic                            tlast_q, tlast_d;

    logic                            slot_free;
    logic                            ready_c;
    logic                            accept;
    logic                            wc_last;
    logic [ROW_CNT_WIDTH-1:0]        row_inc;
    logic                            limit_hit;

    assign slot_free = !tvalid_q || m00_axis_tready;
    assign wc_last   = (word_cnt_q == WC_LAST);
    assign row_inc   = row_cnt_q + ROW_CNT_WIDTH'(1);
    assign limit_hit = (max_rows != '0) && (row_inc == max_rows);
    assign accept    = s00_axis_tvalid && ready_c;

    // Next-state, counter and output-register load decisions
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        row_cnt_d  = row_cnt_q;
        pkt_d      = pkt_q;
        rows_d     = rows_q;
        err_d      = err_q && !err_clr;
        tvalid_d   = slot_free ? 1'b0 : tvalid_q;
        tdata_d    = tdata_q;
        tstrb_d    = tstrb_q;
        tlast_d    = tlast_q;
        ready_c    = 1'b0;

        case (state_q)
            ST_PASS: begin
                ready_c = slot_free;
                if (s00_axis_tvalid && slot_free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = s00_axis_tdata;
                    tstrb_d  = '1;
                    tlast_d  = 1'b0;
                    pkt_d    = 1'b1;
                    if (!pkt_q) begin
                        rows_d = '0;
                    end
                    if (wc_last) begin
                        rows_d = row_inc;
                    end
                    if (s00_axis_tlast && wc_last) begin
                        tlast_d    = 1'b1;
                        word_cnt_d = '0;
                        row_cnt_d  = '0;
                        pkt_d      = 1'b0;
                    end else if (s00_axis_tlast) begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                        state_d    = ST_PAD;
                    end else if (wc_last && limit_hit) begin
                        tlast_d    = 1'b1;
                        err_d      = 1'b1;
                        word_cnt_d = '0;
                        row_cnt_d  = '0;
                        state_d    = ST_DROP;
                    end else if (wc_last) begin
                        word_cnt_d = '0;
                        row_cnt_d  = row_inc;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
            end
            ST_PAD: begin
                if (slot_free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = PAD_WORD;
                    tstrb_d  = '0;
                    tlast_d  = wc_last;
                    if (wc_last) begin
                        word_cnt_d = '0;
                        row_cnt_d  = '0;
                        rows_d     = row_inc;
                        pkt_d      = 1'b0;
                        state_d    = ST_PASS;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
            end
            ST_DROP: begin
                ready_c = 1'b1;
                if (accept && s00_axis_tlast) begin
                    word_cnt_d = '0;
                    row_cnt_d  = '0;
                    pkt_d      = 1'b0;
                    state_d    = ST_PASS;
                end
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    // State, counters and the single output register stage
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q    <= ST_PASS;
            word_cnt_q <= '0;
            row_cnt_q  <= '0;
            pkt_q      <= 1'b0;
            rows_q     <= '0;
            err_q      <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tstrb_q    <= '0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            row_cnt_q  <= row_cnt_d;
            pkt_q      <= pkt_d;
            rows_q     <= rows_d;
            err_q      <= err_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tstrb_q    <= tstrb_d;
            tlast_q    <= tlast_d;
        end
    end

    // Ready is forced low while reset is held, independent of the clock
    assign s00_axis_tready = s00_axis_aresetn && ready_c;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tstrb  = tstrb_q;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
    assign rows_emitted    = rows_q;
    assign overflow_err    = err_q;

endmodule

// File: tb/tb_axis_row_padder.sv
// Self-checking bench for axis_row_padder: table-driven packets, hand-written corner
// sequences and randomized packets scored against a row-arithmetic reference model.
module tb_axis_row_padder;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 4;
    localparam int unsigned CW = 12;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic [CW-1:0] max_rows = '0;
    logic [CW-1:0] rows_emitted;
    logic          overflow_err;
    logic          err_clr = 1'b0;

    always #5 clk = ~clk;

    axis_row_padder #(
        .C_AXIS_TDATA_WIDTH(DW),
        .ROW_WORDS(RW),
        .ROW_CNT_WIDTH(CW),
        .PAD_WORD('0)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tlast(s_tlast),
        .s00_axis_tready(s_tready),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tstrb(m_tstrb),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tready(m_tready),
        .max_rows(max_rows),
        .rows_emitted(rows_emitted),
        .overflow_err(overflow_err),
        .err_clr(err_clr)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: constant 1 or random per cycle
    bit rnd_ready = 1'b0;
    bit rnd_gap   = 1'b0;
    always @(posedge clk) begin
        #1;
        m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: collects transferred words and checks stability under stall
    logic [DW-1:0] q_data[$];
    logic [SW-1:0] q_strb[$];
    logic          q_last[$];
    bit            stall_p = 1'b0;
    logic [DW-1:0] stall_d;
    logic [SW-1:0] stall_s;
    logic          stall_l;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                check("stall_hold", 64'({m_tvalid, m_tlast, m_tstrb, m_tdata}),
                      64'({1'b1, stall_l, stall_s, stall_d}));
            end
            if (m_tvalid && m_tready) begin
                q_data.push_back(m_tdata);
                q_strb.push_back(m_tstrb);
                q_last.push_back(m_tlast);
            end
            stall_p = m_tvalid && !m_tready;
            stall_d = m_tdata;
            stall_s = m_tstrb;
            stall_l = m_tlast;
        end
    end

    task automatic flush();
        q_data.delete();
        q_strb.delete();
        q_last.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the last handshake
    task automatic send_words(input int n, input logic [DW-1:0] vals[$], input bit with_last);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int guard;
            if (rnd_gap && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = vals[i];
            s_tlast  = with_last && (i == n - 1);
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 500) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk); #1;
                guard++;
            end
            check("send_accept", 64'(acc), 64'(1));
            if (!acc) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Reference model: rows needed, words kept, whether the row limit truncates
    function automatic void model(input int n, input int mr,
                                  output int keep, output int total, output int rows, output bit ovf);
        ovf   = (mr != 0) && (n > mr * int'(RW));
        keep  = ovf ? mr * int'(RW) : n;
        rows  = (keep + int'(RW) - 1) / int'(RW);
        total = rows * int'(RW);
    endfunction

    task automatic run_pkt(input string tag, input int n, input int mr, input bit rr, input bit gaps,
                           input logic [DW-1:0] vals[$],
                           input int exp_cnt, input int exp_rows, input bit exp_err);
        int keep, total, rows, guard;
        bit ovf;
        model(n, mr, keep, total, rows, ovf);
        max_rows  = CW'(mr);
        rnd_ready = rr;
        rnd_gap   = gaps;
        flush();
        send_words(n, vals, 1'b1);
        guard = 0;
        while (q_data.size() < exp_cnt && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        rnd_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(q_data.size()), 64'(exp_cnt));
        for (int i = 0; i < total && i < q_data.size(); i++) begin
            logic [DW-1:0] ed;
            ed = (i < keep) ? vals[i] : '0;
            check({tag, "_data"}, 64'(q_data[i]), 64'(ed));
            check({tag, "_strb"}, 64'(q_strb[i]), (i < keep) ? 64'({SW{1'b1}}) : 64'(0));
            check({tag, "_last"}, 64'(q_last[i]), 64'(i == total - 1));
        end
        check({tag, "_rows"}, 64'(rows_emitted), 64'(exp_rows));
        check({tag, "_err"}, 64'(overflow_err), 64'(exp_err));
        if (exp_err) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_err_sticky"}, 64'(overflow_err), 64'(1));
            err_clr = 1'b1;
            @(posedge clk); #1;
            err_clr = 1'b0;
            check({tag, "_err_clr"}, 64'(overflow_err), 64'(0));
        end
    endtask

    typedef struct {
        int len;
        int mr;
        bit rr;
        int exp_cnt;
        int exp_rows;
        bit exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] vals[$];

        tbl[0] = '{8,  0, 1'b0, 8,  2, 1'b0};
        tbl[1] = '{5,  0, 1'b0, 8,  2, 1'b0};
        tbl[2] = '{11, 2, 1'b0, 8,  2, 1'b1};
        tbl[3] = '{8,  2, 1'b0, 8,  2, 1'b0};
        tbl[4] = '{5,  0, 1'b1, 8,  2, 1'b0};
        tbl[5] = '{1,  0, 1'b0, 4,  1, 1'b0};
        tbl[6] = '{4,  1, 1'b1, 4,  1, 1'b0};
        tbl[7] = '{9,  1, 1'b1, 4,  1, 1'b1};
        tbl[8] = '{12, 3, 1'b1, 12, 3, 1'b0};
        tbl[9] = '{13, 3, 1'b0, 12, 3, 1'b1};

        // Reset state
        #12;
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_s_tready", 64'(s_tready), 64'(0));
        check("rst_rows", 64'(rows_emitted), 64'(0));
        check("rst_err", 64'(overflow_err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven packets with sequential word values
        for (int t = 0; t < 10; t++) begin
            vals.delete();
            for (int i = 0; i < tbl[t].len; i++) vals.push_back(DW'(i + 1));
            run_pkt($sformatf("tbl%0d", t), tbl[t].len, tbl[t].mr, tbl[t].rr, 1'b0, vals,
                    tbl[t].exp_cnt, tbl[t].exp_rows, tbl[t].exp_err);
        end

        // One-word packet: latency, pad words and ready low during padding
        max_rows  = '0;
        rnd_ready = 1'b0;
        flush();
        s_tvalid = 1'b1;
        s_tdata  = 32'h0000_00A5;
        s_tlast  = 1'b1;
        @(negedge clk);
        check("lat_pre_valid", 64'(m_tvalid), 64'(0));
        check("lat_pre_ready", 64'(s_tready), 64'(1));
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("pad%0d_word", k), 64'({m_tvalid, m_tlast, m_tstrb, m_tdata}),
                  (k == 1) ? 64'({1'b1, 1'b0, 4'hF, 32'h0000_00A5})
                           : 64'({1'b1, (k == 4), 4'h0, 32'h0}));
            if (k < 4) check($sformatf("pad%0d_s_tready", k), 64'(s_tready), 64'(0));
        end
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check("pad_rows", 64'(rows_emitted), 64'(1));

        // Mid-packet reset, then a fresh aligned packet
        flush();
        vals.delete();
        for (int i = 0; i < 5; i++) vals.push_back(DW'(i + 1));
        send_words(3, vals, 1'b0);
        check("mid_pre_valid", 64'(m_tvalid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(m_tvalid), 64'(0));
        check("mid_rst_last", 64'(m_tlast), 64'(0));
        check("mid_rst_ready", 64'(s_tready), 64'(0));
        check("mid_rst_rows", 64'(rows_emitted), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vals.delete();
        for (int i = 0; i < 4; i++) vals.push_back(DW'(32'h100 + i));
        run_pkt("post_rst", 4, 0, 1'b0, 1'b0, vals, 4, 1, 1'b0);

        // Randomized packets against the reference model
        for (int p = 0; p < 30; p++) begin
            int n, mr, keep, total, rows;
            bit ovf;
            n  = $urandom_range(1, 20);
            mr = $urandom_range(0, 3);
            vals.delete();
            for (int i = 0; i < n; i++) vals.push_back($urandom);
            model(n, mr, keep, total, rows, ovf);
            run_pkt($sformatf("rnd%0d", p), n, mr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    vals, total, rows, ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
